// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the 128-word instruction memory
//
// Purpose:
//   Accepts a little-endian byte stream: a 16-bit word count N followed by
//   N little-endian 32-bit instruction words. Each assembled word is written
//   to the instruction memory with a one-cycle strobe. The CPU is held for the
//   whole session so fetch never sees a half-written program.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   A trailing checksum byte (XOR of all data bytes) is accepted after the
//   last data byte. A mismatch sets err.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   one-cycle pulse, begins a session (ignored while busy)
//   in_valid  in   byte stream valid
//   in_data   in   byte stream data [7:0]
//   in_ready  out  loader accepts a byte this cycle
//   wr_en     out  one-cycle memory write strobe
//   wr_addr   out  word index [AW-1:0]
//   wr_data   out  instruction word [31:0]
//   cpu_hold  out  CPU must stall while high
//   busy      out  session in progress
//   done      out  one-cycle pulse at end of session
//   err       out  sticky error, cleared by the next accepted start
module imem_loader #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state, state_n;
  logic          len_phase, len_phase_n;   // 0: expecting low length byte
  logic [7:0]    len_lo, len_lo_n;
  logic [AW:0]   n_words, n_words_n;
  logic [AW:0]   word_idx, word_idx_n;
  logic [1:0]    byte_cnt, byte_cnt_n;
  logic [23:0]   word_buf, word_buf_n;     // first three bytes of the current word
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum, csum_n;
`endif

  logic          in_ready_n, wr_en_n, cpu_hold_n, busy_n, done_n, err_n;
  logic [AW-1:0] wr_addr_n;
  logic [31:0]   wr_data_n;

  logic          accept;
  logic [15:0]   len_word;

  assign accept   = in_valid & in_ready;
  assign len_word = {in_data, len_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_phase <= 1'b0;
      len_lo    <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      word_buf  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      len_phase <= len_phase_n;
      len_lo    <= len_lo_n;
      n_words   <= n_words_n;
      word_idx  <= word_idx_n;
      byte_cnt  <= byte_cnt_n;
      word_buf  <= word_buf_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= csum_n;
`endif
      in_ready  <= in_ready_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      cpu_hold  <= cpu_hold_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    len_phase_n = len_phase;
    len_lo_n    = len_lo;
    n_words_n   = n_words;
    word_idx_n  = word_idx;
    byte_cnt_n  = byte_cnt;
    word_buf_n  = word_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_n      = csum;
`endif
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    cpu_hold_n  = cpu_hold;
    busy_n      = busy;
    done_n      = 1'b0;
    err_n       = err;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n     = S_LEN;
          busy_n      = 1'b1;
          cpu_hold_n  = 1'b1;
          err_n       = 1'b0;
          len_phase_n = 1'b0;
          word_idx_n  = '0;
          byte_cnt_n  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_n      = '0;
`endif
        end
      end

      S_LEN: begin
        if (accept) begin
          if (!len_phase) begin
            len_lo_n    = in_data;
            len_phase_n = 1'b1;
          end else begin
            len_phase_n = 1'b0;
            // Oversized programs are rejected here so wr_addr can never wrap.
            if (len_word == 16'd0) begin
              state_n = S_DONE;
            end else if (len_word > 16'(DEPTH)) begin
              err_n   = 1'b1;
              state_n = S_DONE;
            end else begin
              n_words_n = len_word[AW:0];
              state_n   = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_n = csum ^ in_data;
`endif
          byte_cnt_n = byte_cnt + 2'd1;
          // Shift right so byte 0 ends up in bits [7:0] after three bytes.
          word_buf_n = {in_data, word_buf[23:8]};
          if (byte_cnt == 2'd3) begin
            wr_en_n    = 1'b1;
            wr_data_n  = {in_data, word_buf};
            wr_addr_n  = word_idx[AW-1:0];
            word_idx_n = word_idx + IDX_ONE;
            if (word_idx == n_words - IDX_ONE) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_n = S_CSUM;
`else
              state_n = S_DONE;
`endif
            end
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (in_data != csum) begin
            err_n = 1'b1;
          end
          state_n = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_n    = S_IDLE;
        done_n     = 1'b1;
        busy_n     = 1'b0;
        cpu_hold_n = 1'b0;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    in_ready_n = (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_CSUM);
`else
    in_ready_n = (state_n == S_LEN) || (state_n == S_DATA);
`endif
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
//
// Purpose: directed and randomized load sessions checked against a reference
//   model built from the byte-stream format (word list -> expected writes,
//   accept cycles -> expected timing). Checksum cases when
//   IMEM_LOADER_CHECKSUM_EN is defined.
// Ports: none (top-level bench).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(128), .AW(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          wq_hold[$];
  int          done_q[$];
  int          hold_bad = 0;
  int          ir_bad = 0;

  logic [31:0] words[$];
  int          acc[$];

  // Observer: records every write and done pulse, and invariants between outputs.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
      wq_hold.push_back(int'(cpu_hold));
    end
    if (done === 1'b1) done_q.push_back(cyc);
    if (busy !== cpu_hold) hold_bad++;
    if (in_ready === 1'b1 && busy !== 1'b1) ir_bad++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input string nm);
    int k;
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk({nm, "_accept_timeout"}, 0, 1);
    @(negedge clk);
    acc.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic run_session(input int hdr, input int gap_max, input bit noise,
                             input bit bad_csum, input string nm);
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [15:0] h;
    int exp_n, exp_err, k, g;
    bit in_range;

    wq_addr = {}; wq_data = {}; wq_cyc = {}; wq_hold = {};
    done_q = {}; acc = {}; hold_bad = 0; ir_bad = 0;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_at_start"}, busy, 1);
    chk({nm, "_hold_at_start"}, cpu_hold, 1);
    chk({nm, "_err_cleared"}, err, 0);

    in_range = (hdr >= 1) && (hdr <= 128);
    h = hdr[15:0];
    bytes = {h[7:0], h[15:8]};
    x = 8'h00;
    if (in_range) begin
      for (int i = 0; i < hdr; i++) begin
        for (int b = 0; b < 4; b++) begin
          bytes.push_back(words[i][8*b +: 8]);
          x = x ^ words[i][8*b +: 8];
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      bytes.push_back(bad_csum ? (x ^ 8'h01) : x);
`endif
    end

    foreach (bytes[i]) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        if (noise && $urandom_range(0, 2) == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(bytes[i], nm);
    end

    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk({nm, "_done_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
    #1;

    chk({nm, "_done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) chk({nm, "_done_cycle"}, done_q[0], acc[acc.size()-1] + 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_hold_end"}, cpu_hold, 0);
    chk({nm, "_ready_end"}, in_ready, 0);

    exp_err = (hdr > 128) ? 1 : 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (in_range && bad_csum) exp_err = 1;
`endif
    chk({nm, "_err"}, err, exp_err);

    exp_n = in_range ? hdr : 0;
    chk({nm, "_write_count"}, wq_addr.size(), exp_n);
    for (int i = 0; i < exp_n && i < wq_addr.size(); i++) begin
      chk({nm, "_wr_addr"}, wq_addr[i], i);
      chk({nm, "_wr_data"}, wq_data[i], words[i]);
      chk({nm, "_wr_cycle"}, wq_cyc[i], acc[2 + 4*i + 3]);
      chk({nm, "_hold_at_write"}, wq_hold[i], 1);
    end
    chk({nm, "_hold_eq_busy"}, hold_bad, 0);
    chk({nm, "_ready_outside_busy"}, ir_bad, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    words = {32'h00000013};
    run_session(1, 0, 0, 0, "t1_single");

    words = {32'h019806B3, 32'h408282B3, 32'h003170B3};
    run_session(3, 0, 0, 0, "t2_three");

    words = {};
    run_session(129, 0, 0, 0, "t3_oversize");

    words = {};
    run_session(0, 0, 0, 0, "zero_len");

    words = {32'h019806B3, 32'h408282B3};
    run_session(2, 5, 1, 0, "t4_gaps");

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 6));
      words = {};
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_session(n, int'($urandom_range(0, 3)), 1, 0, "rnd");
    end

    words = {};
    for (int i = 0; i < 128; i++) words.push_back($urandom);
    run_session(128, 0, 0, 0, "max_len");

    // Abort in the middle of a session.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = {};
    send_byte(8'h02, "t5");
    send_byte(8'h00, "t5");
    send_byte(8'hB3, "t5");
    send_byte(8'h06, "t5");
    send_byte(8'h98, "t5");
    send_byte(8'h01, "t5");
    chk("t5_write_before_rst", wr_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_wr_en", wr_en, 0);
    chk("t5_rst_wr_addr", wr_addr, 0);
    chk("t5_rst_wr_data", wr_data, 0);
    chk("t5_rst_hold", cpu_hold, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    words = {32'hDEADBEEF, 32'h00500093};
    run_session(2, 2, 0, 0, "t5_reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
    words = {32'h00000013};
    run_session(1, 0, 0, 0, "t6_csum_ok");
    words = {32'h00000013};
    run_session(1, 0, 0, 1, "t6_csum_bad");
    words = {32'h019806B3, 32'h408282B3};
    run_session(2, 3, 1, 0, "t6_csum_gaps");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
